// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a shared multicycle MIPS datapath with one ALU and one
// unified memory. Each state issues one datapath operation:
//   FETCH -> DECODE -> (EXEC_R | EXEC_I | MEM_ADDR | BRANCH | JUMP) -> ...
// The FSM stalls in FETCH, MEM_RD and MEM_WR until mem_ready is high, and it
// counts retired instructions.
//
// Parameters
//   CNT_W          width of the retired-instruction counter (wraps)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   OP             IR[31:26], held stable from DECODE until the next FETCH
//   mem_ready      memory access completes this cycle
//   PCWrite        unconditional PC load
//   PCWriteCondEQ  PC load if ALU zero
//   PCWriteCondNE  PC load if ALU not zero
//   IorD           memory address select: 0=PC, 1=ALUOut
//   MemRead        memory read strobe
//   MemWrite       memory write strobe
//   IRWrite        instruction register load
//   MemtoReg       reg write data: 00=ALUOut, 01=MDR, 10=PC
//   RegDst         destination reg: 00=rt, 01=rd, 10=$31
//   RegWrite       register file write
//   ALUSrcA        ALU A: 0=PC, 1=rs
//   ALUSrcB        ALU B: 00=rt, 01=4, 10=sext imm, 11=sext imm<<2
//   ALUOp          000 add, 001 sub, 111 funct, 100 addi, 101 ori,
//                  110 andi, 011 lui
//   PCSource       00=ALU result, 01=ALUOut, 10=jump target
//   state_o        current state encoding (debug)
//   retired        retired-instruction count, wraps mod 2^CNT_W
//   illegal_op     (ILLEGAL_TRAP_EN only) high while parked in TRAP
//
// Build option
//   ILLEGAL_TRAP_EN  when defined, an unsupported opcode parks the FSM in a
//                    sticky TRAP state until reset. When undefined, it is
//                    treated as a NOP that is not counted as retired.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCondEQ,
  output logic             PCWriteCondNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    LW_WB    = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
`ifdef ILLEGAL_TRAP_EN
    TRAP     = 4'd12,
`endif
    JUMP     = 4'd11
  } state_t;

  state_t state, next_state;
  logic   retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Outputs are a pure function of the registered state (plus mem_ready in
  // FETCH), so an asynchronous reset forces them to 0 in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    next_state    = state;
    retire        = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 2'b00;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    PCSource      = 2'b00;

    unique case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        // PC+4 is computed by the ALU while the instruction is read.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) next_state = DECODE;
      end

      DECODE: begin
        // Branch target precomputed into ALUOut in case this is a branch.
        ALUSrcB = 2'b11;
        case (OP)
          OP_RTYPE:                         next_state = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = EXEC_I;
          OP_LW, OP_SW:                     next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:                   next_state = BRANCH;
          OP_J, OP_JAL:                     next_state = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                          next_state = TRAP;
`else
          default:                          next_state = FETCH;
`endif
        endcase
      end

      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 3'b111;
        next_state = ALU_WB;
      end

      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          OP_ORI:  ALUOp = 3'b101;
          OP_ANDI: ALUOp = 3'b110;
          OP_LUI:  ALUOp = 3'b011;
          default: ALUOp = 3'b100;
        endcase
        next_state = ALU_WB;
      end

      ALU_WB: begin
        RegWrite   = 1'b1;
        RegDst     = (OP == OP_RTYPE) ? 2'b01 : 2'b00;
        retire     = 1'b1;
        next_state = FETCH;
      end

      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (OP == OP_SW) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) next_state = LW_WB;
      end

      LW_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        retire     = 1'b1;
        next_state = FETCH;
      end

      MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end

      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 3'b001;
        PCSource      = 2'b01;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
        retire        = 1'b1;
        next_state    = FETCH;
      end

      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        if (OP == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        retire     = 1'b1;
        next_state = FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      TRAP: next_state = TRAP;
`endif

      default: next_state = IDLE;
    endcase
  end

  assign state_o = state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state == TRAP);
`endif

endmodule
